// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter among NUM_REQ byte sources; a grant is held
// for a whole packet (up to req_last). Optional macro UART_ARB_TIMEOUT_EN drops grants idle for TIMEOUT_CYCLES.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int ID_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*8-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [7:0]             uart_data_in,
    output logic                   uart_write_en,
    input  logic                   uart_write_busy,
    output logic                   grant_valid,
    output logic [ID_W-1:0]        grant_id
);

    // Handshake: a byte of requester i transfers on a rising clk edge where req_valid[i] && req_ready[i];
    // req_ready never depends on anything but state, grant_id, req_valid[owner] and uart_write_busy.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_OWN   = 3'd1,
        S_SEND  = 3'd2,
        S_GUARD = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t          state, state_nx;
    logic [ID_W-1:0] ptr, ptr_nx;
    logic [ID_W-1:0] grant_id_nx;
    logic            grant_valid_nx;
    logic [7:0]      data_nx;
    logic            last_q, last_nx;
    logic            write_en_nx;

    logic [ID_W-1:0] pick;
    logic            pick_found;
    logic            own_valid;
    logic [7:0]      own_data;
    logic            own_last;
    logic            accept;
    logic            to_hit;

    // Scan from ptr+1 upwards; iterating k downwards lets the smallest offset win.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && (i == ((int'(ptr) + 1 + k) % NUM_REQ))) begin
                    pick       = ID_W'(i);
                    pick_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        own_valid = 1'b0;
        own_data  = 8'h00;
        own_last  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == grant_id) begin
                own_valid = req_valid[i];
                own_data  = req_data[8*i +: 8];
                own_last  = req_last[i];
            end
        end
    end

    assign accept = (state == S_OWN) && own_valid && !uart_write_busy;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = accept && (ID_W'(i) == grant_id);
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TO_W-1:0] to_cnt, to_cnt_nx;

    // Counts only owner-idle cycles in OWN; a busy UART with a waiting owner is not idleness.
    assign to_hit = (state == S_OWN) && !own_valid && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        to_cnt_nx = to_cnt;
        if ((state != S_OWN) || accept || to_hit) begin
            to_cnt_nx = '0;
        end else if (!own_valid) begin
            to_cnt_nx = to_cnt + TO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt_nx;
        end
    end
`else
    logic unused_timeout_cfg;

    assign to_hit             = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        state_nx       = state;
        ptr_nx         = ptr;
        grant_id_nx    = grant_id;
        grant_valid_nx = grant_valid;
        data_nx        = uart_data_in;
        last_nx        = last_q;
        write_en_nx    = 1'b0;
        case (state)
            S_IDLE: begin
                if (pick_found) begin
                    grant_id_nx    = pick;
                    grant_valid_nx = 1'b1;
                    state_nx       = S_OWN;
                end
            end
            S_OWN: begin
                if (accept) begin
                    data_nx     = own_data;
                    last_nx     = own_last;
                    write_en_nx = 1'b1;
                    state_nx    = S_SEND;
                end else if (to_hit) begin
                    ptr_nx         = grant_id;
                    grant_valid_nx = 1'b0;
                    state_nx       = S_IDLE;
                end
            end
            S_SEND: begin
                state_nx = S_GUARD;
            end
            // The UART raises busy one cycle after write_en, so busy is not trusted here.
            S_GUARD: begin
                state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                if (!uart_write_busy) begin
                    if (last_q) begin
                        ptr_nx         = grant_id;
                        grant_valid_nx = 1'b0;
                        state_nx       = S_IDLE;
                    end else begin
                        state_nx = S_OWN;
                    end
                end
            end
            default: begin
                grant_valid_nx = 1'b0;
                state_nx       = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            ptr           <= ID_W'(NUM_REQ - 1);
            grant_id      <= '0;
            grant_valid   <= 1'b0;
            uart_data_in  <= 8'h00;
            last_q        <= 1'b0;
            uart_write_en <= 1'b0;
        end else begin
            state         <= state_nx;
            ptr           <= ptr_nx;
            grant_id      <= grant_id_nx;
            grant_valid   <= grant_valid_nx;
            uart_data_in  <= data_nx;
            last_q        <= last_nx;
            uart_write_en <= write_en_nx;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: 4-requester instance against a busy-for-N-cycles UART model,
// plus a 1-requester instance; expected bytes go to exp_q and are compared with what the UART received.
module tb_uart_tx_arbiter;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*8-1:0] req_data = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_ready;
    logic [7:0]     uart_data_in;
    logic           uart_write_en;
    logic           uart_write_busy;
    logic           grant_valid;
    logic [1:0]     grant_id;

    logic [0:0]     s_valid = 1'b0;
    logic [7:0]     s_data = 8'h00;
    logic [0:0]     s_last = 1'b0;
    logic [0:0]     s_ready;
    logic [7:0]     s_din;
    logic           s_wen;
    logic           s_busy;
    logic           s_gv;
    logic [0:0]     s_gid;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(50)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .uart_data_in(uart_data_in), .uart_write_en(uart_write_en), .uart_write_busy(uart_write_busy),
        .grant_valid(grant_valid), .grant_id(grant_id)
    );

    uart_tx_arbiter #(.NUM_REQ(1), .TIMEOUT_CYCLES(50)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(s_valid), .req_data(s_data), .req_last(s_last), .req_ready(s_ready),
        .uart_data_in(s_din), .uart_write_en(s_wen), .uart_write_busy(s_busy),
        .grant_valid(s_gv), .grant_id(s_gid)
    );

    // ---------------- UART models (not reset: a byte in flight finishes on its own) ----------------
    int   busy_len = 10;
    int   busy_cnt = 0;
    logic hold_busy = 1'b0;
    int   s_busy_cnt = 0;

    always @(posedge clk) begin
        if (uart_write_en) busy_cnt <= busy_len;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
        if (s_wen) s_busy_cnt <= 3;
        else if (s_busy_cnt > 0) s_busy_cnt <= s_busy_cnt - 1;
    end
    assign uart_write_busy = (busy_cnt != 0) || hold_busy;
    assign s_busy          = (s_busy_cnt != 0);

    // ---------------- requester drivers ----------------
    logic [8:0] src_mem [N][64];
    int         src_wr [N] = '{default: 0};
    int         src_rd [N] = '{default: 0};
    logic [N-1:0] acc_q = '0;

    always @(posedge clk) acc_q <= req_valid & req_ready;

    always @(negedge clk) begin
        int r;
        for (int i = 0; i < N; i++) begin
            r = src_rd[i];
            if (!rst_n) r = src_wr[i];
            else if (acc_q[i]) r = r + 1;
            src_rd[i] <= r;
            if (r < src_wr[i]) begin
                req_valid[i]       <= 1'b1;
                req_data[8*i +: 8] <= src_mem[i][r][7:0];
                req_last[i]        <= src_mem[i][r][8];
            end else begin
                req_valid[i]       <= 1'b0;
                req_data[8*i +: 8] <= 8'h00;
                req_last[i]        <= 1'b0;
            end
        end
    end

    task automatic load(input int id, input logic [7:0] d, input logic last);
        src_mem[id][src_wr[id]] = {last, d};
        src_wr[id] = src_wr[id] + 1;
    endtask

    // ---------------- monitors / scoreboard ----------------
    logic [11:0] exp_q[$];
    logic [11:0] got_q[$];
    logic [7:0]  exp1_q[$];
    logic [7:0]  got1_q[$];
    int          gnt_q[$];
    int          gnt_cyc_q[$];
    int          cyc = 0;
    int          busy_fall_cyc = 0;
    int          viol_cnt = 0;
    int          s_viol_cnt = 0;
    logic        prev_wen = 1'b0, prev_busy = 1'b0, prev_gv = 1'b0;
    logic        s_prev_wen = 1'b0, s_prev_busy = 1'b0;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        prev_wen    <= uart_write_en;
        prev_busy   <= uart_write_busy;
        prev_gv     <= grant_valid;
        s_prev_wen  <= s_wen;
        s_prev_busy <= s_busy;
        if (uart_write_en) got_q.push_back({2'b00, grant_id, uart_data_in});
        if (uart_write_en && (prev_wen || prev_busy)) viol_cnt <= viol_cnt + 1;
        if (grant_valid && !prev_gv) begin
            gnt_q.push_back(int'(grant_id));
            gnt_cyc_q.push_back(cyc);
        end
        if (!uart_write_busy && prev_busy) busy_fall_cyc <= cyc;
        if (s_wen) got1_q.push_back(s_din);
        if ((s_wen && (s_prev_wen || s_prev_busy)) || (s_gv && s_gid != 1'b0)) s_viol_cnt <= s_viol_cnt + 1;
    end

    task automatic do_reset();
        for (int c = 0; c < 200 && uart_write_busy; c++) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        got_q.delete();
        gnt_q.delete();
        gnt_cyc_q.delete();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int n, input int budget);
        for (int c = 0; c < budget && !(got_q.size() >= n && !grant_valid); c++) @(negedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (uart_write_en !== 1'b0 || uart_data_in !== 8'h00 || req_ready !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: wen=%b din=%h ready=%b, required 0 00 0000", uart_write_en, uart_data_in, req_ready);
        end
        n_checks++;
        if (grant_valid !== 1'b0 || grant_id !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_grant: gv=%b gid=%0d, required 0 0", grant_valid, grant_id);
        end
        n_checks++;
        if (s_wen !== 1'b0 || s_gv !== 1'b0 || s_ready !== 1'b0 || s_din !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_single: wen=%b gv=%b ready=%b din=%h, required all 0", s_wen, s_gv, s_ready, s_din);
        end
        rst_n = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic test_single_packet();
        do_reset();
        busy_len = 10;
        load(0, 8'h41, 1'b0); exp_q.push_back({4'd0, 8'h41});
        load(0, 8'h42, 1'b0); exp_q.push_back({4'd0, 8'h42});
        load(0, 8'h43, 1'b1); exp_q.push_back({4'd0, 8'h43});
        @(negedge clk); #1;
        n_checks++;
        if (req_valid[0] !== 1'b1 || grant_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL first_select: valid=%b gv=%b, required 1 0", req_valid[0], grant_valid);
        end
        @(negedge clk); #1;
        n_checks++;
        if (grant_valid !== 1'b1 || req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL first_ready: gv=%b ready=%b, required 1 0001", grant_valid, req_ready);
        end
        @(negedge clk); #1;
        n_checks++;
        if (uart_write_en !== 1'b1 || uart_data_in !== 8'h41) begin
            n_fail++;
            $display("FAIL first_pulse: wen=%b din=%h, required 1 41", uart_write_en, uart_data_in);
        end
        wait_done(3, 300);
        n_checks++;
        if (got_q.size() != 3 || grant_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL packet_pulses: pulses=%0d gv=%b, required 3 0", got_q.size(), grant_valid);
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            logic [11:0] e, g;
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL packet_data: got id/byte %h, required %h", g, e);
            end
        end
    endtask

    task automatic test_two_simultaneous();
        do_reset();
        busy_len = 4;
        load(1, 8'h11, 1'b0); load(1, 8'h12, 1'b1);
        load(2, 8'h21, 1'b0); load(2, 8'h22, 1'b1);
        exp_q.push_back({4'd1, 8'h11}); exp_q.push_back({4'd1, 8'h12});
        exp_q.push_back({4'd2, 8'h21}); exp_q.push_back({4'd2, 8'h22});
        wait_done(4, 300);
        n_checks++;
        if (gnt_q.size() != 2 || gnt_q[0] != 1 || gnt_q[1] != 2) begin
            n_fail++;
            $display("FAIL simul_grant_order: grants=%0d first=%0d, required 2 grants 1 then 2",
                     gnt_q.size(), (gnt_q.size() > 0) ? gnt_q[0] : -1);
        end
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL simul_count: got %0d bytes, required %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            logic [11:0] e, g;
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL simul_data: got id/byte %h, required %h", g, e);
            end
        end
    endtask

    task automatic test_alternate();
        do_reset();
        busy_len = 3;
        for (int p = 0; p < 4; p++) begin
            load(0, 8'(8'h60 + 2 * p), 1'b0); load(0, 8'(8'h61 + 2 * p), 1'b1);
            load(3, 8'(8'h90 + 2 * p), 1'b0); load(3, 8'(8'h91 + 2 * p), 1'b1);
            exp_q.push_back({4'd0, 8'(8'h60 + 2 * p)}); exp_q.push_back({4'd0, 8'(8'h61 + 2 * p)});
            exp_q.push_back({4'd3, 8'(8'h90 + 2 * p)}); exp_q.push_back({4'd3, 8'(8'h91 + 2 * p)});
        end
        wait_done(16, 1000);
        n_checks++;
        if (gnt_q.size() != 8) begin
            n_fail++;
            $display("FAIL alt_grant_count: got %0d grants, required 8", gnt_q.size());
        end
        for (int k = 0; k < gnt_q.size(); k++) begin
            int want;
            want = (k % 2 == 0) ? 0 : 3;
            n_checks++;
            if (gnt_q[k] != want) begin
                n_fail++;
                $display("FAIL alt_grant_%0d: got %0d, required %0d", k, gnt_q[k], want);
            end
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            logic [11:0] e, g;
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL alt_data: got id/byte %h, required %h", g, e);
            end
        end
    endtask

    task automatic test_held_grant();
        do_reset();
        busy_len = 5;
        load(2, 8'h55, 1'b0);
        exp_q.push_back({4'd2, 8'h55});
        for (int c = 0; c < 50 && gnt_q.size() < 1; c++) @(negedge clk);
        #1;
        load(0, 8'h66, 1'b1);
`ifdef UART_ARB_TIMEOUT_EN
        exp_q.push_back({4'd0, 8'h66});
        for (int c = 0; c < 500 && gnt_q.size() < 2; c++) @(negedge clk);
        #1;
        n_checks++;
        if (gnt_q.size() < 2 || gnt_q[1] != 0 ||
            (gnt_cyc_q[1] - busy_fall_cyc) < 51 || (gnt_cyc_q[1] - busy_fall_cyc) > 53) begin
            n_fail++;
            $display("FAIL timeout_regrant: grants=%0d delay=%0d, required req0 after 51..53 cycles",
                     gnt_q.size(), (gnt_q.size() > 1) ? gnt_cyc_q[1] - busy_fall_cyc : -1);
        end
        load(2, 8'h56, 1'b1);
        exp_q.push_back({4'd2, 8'h56});
`else
        repeat (10000) @(negedge clk);
        #1;
        n_checks++;
        if (gnt_q.size() != 1 || got_q.size() != 1 || grant_valid !== 1'b1 ||
            grant_id !== 2'd2 || req_ready !== 4'h0) begin
            n_fail++;
            $display("FAIL held_grant: grants=%0d bytes=%0d gv=%b gid=%0d ready=%b, required 1 1 1 2 0000",
                     gnt_q.size(), got_q.size(), grant_valid, grant_id, req_ready);
        end
        load(2, 8'h56, 1'b1);
        exp_q.push_back({4'd2, 8'h56});
        exp_q.push_back({4'd0, 8'h66});
`endif
        wait_done(3, 500);
        n_checks++;
        if (got_q.size() != 3) begin
            n_fail++;
            $display("FAIL held_count: got %0d bytes, required 3", got_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            logic [11:0] e, g;
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL held_data: got id/byte %h, required %h", g, e);
            end
        end
    endtask

    task automatic test_reset_in_send();
        int early;
        do_reset();
        busy_len = 10;
        load(1, 8'h77, 1'b1);
        for (int c = 0; c < 50 && uart_write_en !== 1'b1; c++) begin
            @(negedge clk); #1;
        end
        #1;
        rst_n = 1'b0;
        hold_busy = 1'b1;
        #1;
        n_checks++;
        if (uart_write_en !== 1'b0 || grant_valid !== 1'b0 || req_ready !== 4'h0 || uart_data_in !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset: wen=%b gv=%b ready=%b din=%h, required 0 0 0000 00",
                     uart_write_en, grant_valid, req_ready, uart_data_in);
        end
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        got_q.delete();
        gnt_q.delete();
        load(1, 8'h78, 1'b1);
        exp_q.push_back({4'd1, 8'h78});
        early = 0;
        repeat (18) begin
            @(negedge clk); #1;
            if (req_ready !== 4'h0) early++;
        end
        n_checks++;
        if (early != 0) begin
            n_fail++;
            $display("FAIL ready_while_busy: ready seen high %0d cycles, required 0", early);
        end
        hold_busy = 1'b0;
        wait_done(1, 100);
        n_checks++;
        if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            n_fail++;
            $display("FAIL post_reset_byte: got %0d bytes first=%h, required 1 byte %h",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 12'h0, exp_q[0]);
        end
        n_checks++;
        if (viol_cnt != 0) begin
            n_fail++;
            $display("FAIL pulse_rule: %0d write_en pulses after wen or busy, required 0", viol_cnt);
        end
    endtask

    task automatic test_single_requester();
        logic [7:0] bytes [4];
        int idx;
        bytes = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        got1_q.delete();
        for (int i = 0; i < 4; i++) exp1_q.push_back(bytes[i]);
        idx = 0;
        for (int c = 0; c < 400 && idx < 4; c++) begin
            @(negedge clk);
            s_valid = (c % 2 == 0) ? 1'b1 : 1'b0;
            s_data  = bytes[idx];
            s_last  = (idx == 3) ? 1'b1 : 1'b0;
            #1;
            if (s_valid == 1'b1 && s_ready == 1'b1) idx++;
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        for (int c = 0; c < 100 && !(got1_q.size() >= 4 && !s_gv); c++) @(negedge clk);
        #1;
        n_checks++;
        if (got1_q.size() != 4 || s_gid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_count: pulses=%0d gid=%0d, required 4 0", got1_q.size(), s_gid);
        end
        while (exp1_q.size() > 0 && got1_q.size() > 0) begin
            logic [7:0] e, g;
            e = exp1_q.pop_front();
            g = got1_q.pop_front();
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL single_data: got %h, required %h", g, e);
            end
        end
        n_checks++;
        if (s_viol_cnt != 0) begin
            n_fail++;
            $display("FAIL single_rules: %0d pulse or grant_id violations, required 0", s_viol_cnt);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_packet();
        test_two_simultaneous();
        test_alternate();
        test_held_grant();
        test_reset_in_send();
        test_single_requester();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one UART byte transmitter among `NUM_REQ` requesters. It sits between on-chip byte sources (CPU console, debug dump, status reporter, ...) and the UART's `data_in` / `write_en` / `write_busy` port. Grant is held for a whole packet, delimited by `req_last`, so bytes from different sources never interleave.

## Interface

Parameters:
- `NUM_REQ`, default 4: number of requesters; legal range 1..16.
- `TIMEOUT_CYCLES`, default 100000: idle cycles before a held grant is dropped. Only used with `UART_ARB_TIMEOUT_EN`.
- `ID_W`, default `$clog2(NUM_REQ)` with a minimum of 1: width of `grant_id`.

Ports (`clk` and `rst_n`):
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `req_valid`, in, NUM_REQ: per-requester byte valid.
- `req_data`, in, NUM_REQ*8: byte of requester i at bits [8i+7:8i].
- `req_last`, in, NUM_REQ: byte is the last of its packet; sampled with the byte.
- `req_ready`, out, NUM_REQ: one-hot; byte accepted this cycle.
- `uart_data_in`, out, 8: byte to the UART; registered.
- `uart_write_en`, out, 1: one-cycle start pulse to the UART.
- `uart_write_busy`, in, 1: UART transmitter busy.
- `grant_valid`, out, 1: a requester currently owns the UART.
- `grant_id`, out, ID_W: index of the owner; only meaningful when `grant_valid` is high.

## Operation

- **IDLE**
  - If any `req_valid` is high, pick the first requester at or after `ptr+1` (mod NUM_REQ).
  - Latch that index into `grant_id`, set `grant_valid`, and go to OWN.
  - Selection costs 1 cycle; `req_ready` is 0 during IDLE.
- **OWN**
  - `req_ready[g] = req_valid[g] && !uart_write_busy` (combinational, one-hot or zero).
  - On acceptance, latch the byte into `uart_data_in` and its `last` flag, then go to SEND.
- **SEND**
  - `uart_write_en` = 1 for exactly this cycle, then go to GUARD.
- **GUARD**
  - One cycle with `uart_write_busy` ignored, to cover the UART's one-cycle busy rise. Then go to DRAIN.
- **DRAIN**
  - Wait for `uart_write_busy` = 0.
  - If the latched `last` = 1: `ptr` ← g, `grant_valid` ← 0, go to IDLE.
  - Otherwise go back to OWN.
- **Fairness:** the round-robin pointer updates only on packet completion or timeout. A requester that just finished has lowest priority next time.
- **Boundary conditions**
  - Owner deasserts `req_valid` mid-packet: the grant is held. Other requesters stall unless the timeout is compiled in.
  - All requesters request simultaneously after reset: order is 0, 1, 2, 3, 0, ... (`ptr` resets to NUM_REQ-1).
  - `uart_write_busy` already high on entry to OWN (a byte still in flight): `req_ready` stays 0 until busy falls.
  - NUM_REQ = 1: always grants requester 0; `grant_id` = 0.
  - `req_valid` for non-owners is ignored while a grant is held; `req_ready` for them is 0.

## Timing

- **Reset values:** `uart_write_en`=0, `uart_data_in`=8'h00, `req_ready`=0, `grant_valid`=0, `grant_id`=0, `ptr`=NUM_REQ-1, state=IDLE, timeout counter=0.
- **First byte latency:** `req_valid` rising in IDLE → `grant_valid` next cycle → `req_ready` the same cycle as `grant_valid` (if not busy) → `uart_write_en` 1 cycle after acceptance.
- **Back-to-back bytes:** the next `req_ready` comes 1 cycle after busy falls in DRAIN.
- **Reset mid-operation:**
  - All outputs return to reset values asynchronously.
  - A byte already inside the UART completes on its own.
  - After reset, the first acceptance waits for `uart_write_busy` low.
- **Per-byte pulse:** `uart_write_en` is never high for 2 consecutive cycles, and is never high while `uart_write_busy` was sampled high in the previous cycle.

## Configuration

- `UART_ARB_TIMEOUT_EN` defined:
  - A counter runs in OWN while `req_valid[g]` = 0, and clears on acceptance.
  - At `TIMEOUT_CYCLES` the grant is dropped: `ptr` ← g, go to IDLE, `grant_valid` ← 0.
  - The rest of that packet re-arbitrates as a new packet.
- `UART_ARB_TIMEOUT_EN` not defined: no counter. A held grant persists until a `last` byte is sent.

## Test plan

- Reset, then req0 sends 3 bytes 0x41, 0x42, 0x43 (last on 0x43) against a UART model with busy for 10 cycles → exactly 3 `uart_write_en` pulses, data in order, `grant_valid` drops after the third DRAIN.
- req1 and req2 each assert 2-byte packets in the same cycle after reset → req1's two bytes all precede req2's; `grant_id` reads 1 then 2.
- req0 and req3 stream packets continuously → grants alternate 0, 3, 0, 3; no starvation over 8 packets.
- req2 sends a byte without last, then drops `req_valid`; req0 is requesting → without the macro, req0 is never granted in 10000 cycles; with `UART_ARB_TIMEOUT_EN` and TIMEOUT_CYCLES=50, req0 is granted 51–53 cycles after req2's byte drains.
- Assert `rst_n` low in SEND with busy held high by the model for 20 more cycles → `uart_write_en` clears immediately; after release, first `req_ready` only after busy falls.
- NUM_REQ=1 build: a 4-byte packet with `req_valid` toggling every other cycle → 4 pulses with correct data, `grant_id` constant 0.
